// File: rtl/craps_round_ctrl.sv
// craps_round_ctrl: craps round controller; requests dice, scores each roll, drives display results
module craps_round_ctrl #(
    parameter int SUM_W       = 4,
    parameter int RND_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             roll,
    input  logic             new_game,
    input  logic             rnd_valid,
    input  logic [2:0]       die_a,
    input  logic [2:0]       die_b,
    output logic             rnd_req,
    output logic             won,
    output logic             lost,
    output logic [SUM_W-1:0] user_total,
    output logic [SUM_W-1:0] fpga_total,
    output logic [CNT_W-1:0] roll_cnt,
    output logic             busy
);
    localparam int TMO_W = $clog2(RND_TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(RND_TIMEOUT - 1);
    localparam logic [SUM_W-1:0] S2 = SUM_W'(2), S3 = SUM_W'(3), S7 = SUM_W'(7),
                                 S11 = SUM_W'(11), S12 = SUM_W'(12);
    typedef enum logic [2:0] {IDLE, ROLL1, POINT, ROLLN, WON, LOST} state_t;
    state_t           state_q, state_d;
    logic             roll_q, rnd_req_q, rnd_req_d, won_q, won_d, lost_q, lost_d, busy_q, busy_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [SUM_W-1:0] user_total_q, user_total_d, fpga_total_q, fpga_total_d;
    logic [CNT_W-1:0] roll_cnt_q, roll_cnt_d;
    logic             roll_edge, dice_ok, waiting;
    logic [3:0]       sum4;
    logic [SUM_W-1:0] sum;
    assign roll_edge = roll & ~roll_q;
    assign dice_ok   = (die_a != 3'd0) && (die_a != 3'd7) && (die_b != 3'd0) && (die_b != 3'd7);
    assign waiting   = (state_q == ROLL1) || (state_q == ROLLN);
    assign sum4      = 4'(die_a) + 4'(die_b);
    assign sum       = SUM_W'(sum4);
    always_comb begin
        state_d      = state_q;
        tmo_d        = tmo_q;
        rnd_req_d    = 1'b0;
        won_d        = won_q;
        lost_d       = lost_q;
        user_total_d = user_total_q;
        fpga_total_d = fpga_total_q;
        roll_cnt_d   = roll_cnt_q;
        busy_d       = busy_q;
        if (new_game) begin
            state_d      = IDLE;
            tmo_d        = '0;
            won_d        = 1'b0;
            lost_d       = 1'b0;
            user_total_d = '0;
            fpga_total_d = '0;
            roll_cnt_d   = '0;
            busy_d       = 1'b0;
        end else if (waiting && rnd_valid && dice_ok) begin
            tmo_d        = '0;
            user_total_d = sum;
            roll_cnt_d   = &roll_cnt_q ? roll_cnt_q : roll_cnt_q + 1'b1;
            busy_d       = 1'b0;
            if (state_q == ROLL1) begin
                state_d      = (sum == S7 || sum == S11) ? WON :
                               (sum == S2 || sum == S3 || sum == S12) ? LOST : POINT;
                fpga_total_d = (state_d == POINT) ? sum : fpga_total_q;
            end else begin
                state_d = (sum == fpga_total_q) ? WON : (sum == S7) ? LOST : POINT;
            end
            won_d  = (state_d == WON);
            lost_d = (state_d == LOST);
        end else if (waiting) begin
            // a rejected sample or an expired wait both re-request fresh dice
            rnd_req_d = rnd_valid || (tmo_q == TMO_MAX);
            tmo_d     = rnd_req_d ? '0 : tmo_q + 1'b1;
        end else if (roll_edge && (state_q == IDLE || state_q == POINT)) begin
            state_d   = (state_q == IDLE) ? ROLL1 : ROLLN;
            rnd_req_d = 1'b1;
            busy_d    = 1'b1;
            tmo_d     = '0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            roll_q       <= 1'b0;
            tmo_q        <= '0;
            rnd_req_q    <= 1'b0;
            won_q        <= 1'b0;
            lost_q       <= 1'b0;
            user_total_q <= '0;
            fpga_total_q <= '0;
            roll_cnt_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            roll_q       <= roll;
            tmo_q        <= tmo_d;
            rnd_req_q    <= rnd_req_d;
            won_q        <= won_d;
            lost_q       <= lost_d;
            user_total_q <= user_total_d;
            fpga_total_q <= fpga_total_d;
            roll_cnt_q   <= roll_cnt_d;
            busy_q       <= busy_d;
        end
    end
    assign rnd_req    = rnd_req_q;
    assign won        = won_q;
    assign lost       = lost_q;
    assign user_total = user_total_q;
    assign fpga_total = fpga_total_q;
    assign roll_cnt   = roll_cnt_q;
    assign busy       = busy_q;
endmodule

// File: doc/craps_round_ctrl.md
Name: craps_round_ctrl

Overview:
- Game-round controller that sits directly upstream of the seven-segment/LED display stage.
- Turns player roll presses into dice requests to the random-number source, and evaluates each returned pair under craps rules.
- Drives the display-facing result signals: won, lost, user_total (last roll sum) and fpga_total (established point).
- All outputs are registered; the display stage consumes them on the same clock.

Parameters:
- SUM_W, 4, width of user_total/fpga_total; must be >= 4 (max sum 12).
- RND_TIMEOUT, 16, cycles to wait for rnd_valid before re-issuing rnd_req; must be >= 2.
- CNT_W, 8, width of roll_cnt.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- roll  in  1  player roll request (level, already debounced); rising edge is the event.
- new_game  in  1  level; aborts or ends the round and returns to idle.
- rnd_valid  in  1  one-cycle strobe; die_a/die_b are valid in this cycle.
- die_a  in  3  die value, legal range 1..6.
- die_b  in  3  die value, legal range 1..6.
- rnd_req  out  1  one-cycle request pulse to the random source.
- won  out  1  round won (sticky until new_game/rst).
- lost  out  1  round lost (sticky until new_game/rst).
- user_total  out  SUM_W  sum of the last accepted roll.
- fpga_total  out  SUM_W  established point; 0 when no point is set.
- roll_cnt  out  CNT_W  accepted rolls this round; saturates at all-ones.
- busy  out  1  high while waiting for dice.

Behaviour:
- Reset: state IDLE. All outputs are 0, including rnd_req, won, lost, user_total, fpga_total, roll_cnt and busy. Internal roll_q = 0 and timeout counter = 0.
- Edge detect: roll_q <= roll each cycle. roll_edge = roll & ~roll_q.
- States: IDLE, ROLL1, POINT, ROLLN, WON, LOST.
- IDLE, roll_edge at cycle t -> ROLL1. rnd_req = 1 in cycle t+1 only; busy = 1 from t+1.
- POINT, roll_edge -> ROLLN, with the same rnd_req timing as from IDLE.
- ROLL1/ROLLN, wait for rnd_valid:
  - roll_edge is ignored.
  - The timeout counter starts at 0 on entry and increments each cycle without rnd_valid.
  - When it reaches RND_TIMEOUT-1, rnd_req pulses again next cycle and the counter restarts at 0.
- rnd_valid with an illegal die (0 or 7 on either die): the sample is discarded, rnd_req is re-pulsed next cycle, the counter restarts, and the state is unchanged.
- rnd_valid with legal dice at cycle v, all updates visible at v+1:
  - sum = die_a + die_b, zero-extended to SUM_W.
  - user_total <= sum; roll_cnt increments, saturating.
  - busy <= 0.
- ROLL1 evaluation:
  - sum 7 or 11 -> WON, won = 1.
  - sum 2, 3 or 12 -> LOST, lost = 1.
  - Any other sum -> POINT, fpga_total <= sum.
- ROLLN evaluation:
  - sum == fpga_total -> WON, won = 1.
  - sum == 7 -> LOST, lost = 1.
  - Otherwise -> POINT, fpga_total unchanged.
- WON/LOST: roll_edge and rnd_valid are ignored. won and lost are never both 1.
- new_game = 1 in any state -> IDLE next cycle, with won, lost, user_total, fpga_total, roll_cnt, busy and the timeout counter all cleared.
  - new_game has priority over a simultaneous roll_edge or rnd_valid; a rnd_valid arriving in the same cycle is dropped.
  - While new_game is held, the block stays in IDLE.
- Unsolicited rnd_valid in IDLE, POINT, WON or LOST is ignored.
- rst mid-round (any state, including a pending request) -> full reset values next cycle. A late rnd_valid after reset is ignored.
- roll_q keeps updating in all states, so a roll held high across new_game generates no new edge.

Test Plan:
- Natural win: rst, roll 0->1, rnd_valid with dice 3,4 -> rnd_req one cycle after the edge; next cycle user_total=7, won=1, lost=0, fpga_total=0, roll_cnt=1.
- Craps loss: roll, dice 1,1 -> user_total=2, lost=1. A further roll edge produces no rnd_req. new_game -> all outputs 0.
- Point made:
  - roll with dice 2,2 -> fpga_total=4, POINT, won=0.
  - roll with dice 5,3 -> user_total=8, still POINT.
  - roll with dice 1,3 -> won=1, roll_cnt=3, fpga_total=4.
- Seven-out and timeout:
  - point 6 established; roll, withhold rnd_valid -> rnd_req re-pulses every RND_TIMEOUT (16) cycles.
  - Then dice 6,1 -> lost=1, user_total=7.
- Illegal/edge cases:
  - dice 0,5 in ROLL1 -> no state change; rnd_req re-pulsed the next cycle.
  - roll held high across new_game -> no rnd_req.
  - new_game and rnd_valid in the same cycle -> IDLE, outputs 0.
- Reset mid-request: rst while in ROLLN, then rnd_valid with dice 3,4 -> everything remains 0 and the state stays IDLE.
